regfile_sb: RTL and testbench

// - Parametrised multi-port register file for the next datapath generation: 2 write ports, 2 read ports.
// - Optional hardwired-zero R0 and optional write-to-read bypass.
// - Per-register busy scoreboard for hazard detection by the controller.
// - Sequenced bulk-clear engine. Sits between decode (reads, reservations) and writeback (writes).

---
 rtl/regfile_sb.sv | 143 ++++++++++++++
 tb/tb_regfile_sb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// 2W/2R register file with optional zero R0 and write bypass, a per-register busy scoreboard
// for hazard detection, and a sequenced bulk-clear engine that zeroes one register per cycle.
module regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic clearing;
  logic wr_a, wr_b, rsv;

  // The clear engine owns the array: writes, reservations and bypass are all suppressed while it runs.
  assign clearing = (state_q == ST_CLEAR);
  assign wr_a = we_a && !clearing && !((ZERO_REG != 0) && (waddr_a == '0));
  assign wr_b = we_b && !clearing && !((ZERO_REG != 0) && (waddr_b == '0));
  assign rsv  = rsv_en && !clearing && !((ZERO_REG != 0) && (rsv_addr == '0));

  assign clr_busy = clearing;

  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_a) begin
          regs_d[waddr_a] = wdata_a;
          busy_d[waddr_a] = 1'b0;
        end
        // Port B applied after A so it wins on an address collision.
        if (wr_b) begin
          regs_d[waddr_b] = wdata_b;
          busy_d[waddr_b] = 1'b0;
        end
        // A fresh reservation outranks the writeback clear of the same register.
        if (rsv) begin
          busy_d[rsv_addr] = 1'b1;
        end
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        regs_d[cnt_q] = '0;
        busy_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              b_en,
    input logic [ADDR_W-1:0] b_addr,
    input logic [DATA_W-1:0] b_data,
    input logic              a_en,
    input logic [ADDR_W-1:0] a_addr,
    input logic [DATA_W-1:0] a_data
  );
    logic [DATA_W-1:0] r;
    r = stored;
    if (BYPASS != 0) begin
      if (b_en && (b_addr == ra)) begin
        r = b_data;
      end else if (a_en && (a_addr == ra)) begin
        r = a_data;
      end
    end
    if ((ZERO_REG != 0) && (ra == '0)) begin
      r = '0;
    end
    return r;
  endfunction

  always_comb begin
    rdata1 = read_mux(raddr1, regs_q[raddr1], wr_b, waddr_b, wdata_b, wr_a, waddr_a, wdata_a);
    rdata2 = read_mux(raddr2, regs_q[raddr2], wr_b, waddr_b, wdata_b, wr_a, waddr_a, wdata_a);
  end

  always_comb begin
    busy1 = busy_q[raddr1] && !((ZERO_REG != 0) && (raddr1 == '0));
    busy2 = busy_q[raddr2] && !((ZERO_REG != 0) && (raddr2 == '0));
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic against an array-based model.
module tb_regfile_sb;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          we_a, we_b, rsv_en, clr_req;
  logic [AW-1:0] waddr_a, waddr_b, raddr1, raddr2, rsv_addr;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [DW-1:0] rdata1, rdata2;
  logic          busy1, busy2, clr_busy;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [DW-1:0] mem [DEPTH];
  bit            bsy [DEPTH];
  int            clr_left;
  int            clr_idx;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr1(raddr1), .rdata1(rdata1),
    .raddr2(raddr2), .rdata2(rdata2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(busy1), .busy2(busy2),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      bsy[i] = 1'b0;
    end
    clr_left = 0;
    clr_idx  = 0;
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (clr_left == 0 && we_b && waddr_b == a) return wdata_b;
    if (clr_left == 0 && we_a && waddr_a == a) return wdata_a;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return bsy[a];
  endfunction

  task automatic model_update();
    if (clr_left > 0) begin
      mem[clr_idx] = '0;
      bsy[clr_idx] = 1'b0;
      clr_idx++;
      clr_left--;
    end else begin
      if (we_a && waddr_a != 0) begin mem[waddr_a] = wdata_a; bsy[waddr_a] = 1'b0; end
      if (we_b && waddr_b != 0) begin mem[waddr_b] = wdata_b; bsy[waddr_b] = 1'b0; end
      if (rsv_en && rsv_addr != 0) bsy[rsv_addr] = 1'b1;
      if (clr_req) begin clr_left = DEPTH; clr_idx = 0; end
    end
  endtask

  task automatic idle_inputs();
    we_a = 0; waddr_a = '0; wdata_a = '0;
    we_b = 0; waddr_b = '0; wdata_b = '0;
    rsv_en = 0; rsv_addr = '0; clr_req = 0;
  endtask

  // Inputs are driven just after a rising edge; outputs are checked on the falling edge,
  // then the model advances on the next rising edge.
  task automatic cycle();
    @(negedge clk);
    check_eq("rdata1", rdata1, exp_read(raddr1));
    check_eq("rdata2", rdata2, exp_read(raddr2));
    check_eq("busy1", busy1, exp_busy(raddr1));
    check_eq("busy2", busy2, exp_busy(raddr2));
    check_eq("clr_busy", clr_busy, clr_left > 0);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic sweep_zero(input string tag);
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      raddr1 = i[AW-1:0];
      raddr2 = i[AW-1:0];
      #1;
      check_eq({tag, "_rd"}, rdata1, 0);
      check_eq({tag, "_busy"}, busy2, 0);
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    raddr1 = '0; raddr2 = '0;
    rst = 1'b1;
    model_reset();
    #12;
    check_eq("reset_clr_busy", clr_busy, 0);
    sweep_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Write A addr3 with same-cycle bypass on read port 2, then plain read.
    we_a = 1; waddr_a = 3; wdata_a = 8'hA5; raddr2 = 3;
    #1 check_eq("bypass_a", rdata2, 8'hA5);
    cycle();
    idle_inputs(); raddr1 = 3;
    #1 check_eq("read_a5", rdata1, 8'hA5);
    cycle();

    // Dual write collision: port B wins.
    we_a = 1; waddr_a = 5; wdata_a = 8'h11;
    we_b = 1; waddr_b = 5; wdata_b = 8'h22; raddr1 = 5;
    #1 check_eq("bypass_b_prio", rdata1, 8'h22);
    cycle();
    idle_inputs();
    #1 check_eq("collide_b_wins", rdata1, 8'h22);
    cycle();

    // Zero register ignores writes and reservations.
    we_a = 1; waddr_a = 0; wdata_a = 8'hFF; raddr1 = 0;
    #1 check_eq("r0_bypass", rdata1, 0);
    cycle();
    idle_inputs(); rsv_en = 1; rsv_addr = 0;
    cycle();
    idle_inputs();
    #1 check_eq("r0_read", rdata1, 0);
    check_eq("r0_busy", busy1, 0);

    // Scoreboard.
    rsv_en = 1; rsv_addr = 2; raddr1 = 2;
    cycle();
    idle_inputs();
    #1 check_eq("rsv_set", busy1, 1);
    we_a = 1; waddr_a = 2; wdata_a = 8'h33;
    cycle();
    idle_inputs();
    #1 check_eq("wr_clears_busy", busy1, 0);
    rsv_en = 1; rsv_addr = 2; we_b = 1; waddr_b = 2; wdata_b = 8'h44;
    cycle();
    idle_inputs();
    #1 check_eq("rsv_wins", busy1, 1);

    // Fill, then bulk clear with writes attempted throughout.
    for (int i = 1; i < DEPTH; i++) begin
      we_a = 1; waddr_a = i[AW-1:0]; wdata_a = 8'(i * 16 + 1);
      cycle();
    end
    idle_inputs(); rsv_en = 1; rsv_addr = 6;
    clr_req = 1;
    cycle();
    n = 0;
    while (clr_busy && n < 20) begin
      we_a = 1; waddr_a = AW'($urandom_range(1, 7)); wdata_a = 8'hEE;
      we_b = 1; waddr_b = AW'($urandom_range(1, 7)); wdata_b = 8'hDD;
      rsv_en = 1; rsv_addr = AW'($urandom_range(1, 7));
      raddr1 = waddr_a; raddr2 = waddr_b;
      cycle();
      n++;
    end
    check_eq("clear_len", n, DEPTH);
    sweep_zero("after_clear");

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      we_a = 1'($urandom_range(0, 1)); waddr_a = AW'($urandom); wdata_a = DW'($urandom);
      we_b = 1'($urandom_range(0, 1)); waddr_b = AW'($urandom); wdata_b = DW'($urandom);
      rsv_en = ($urandom_range(0, 3) == 0); rsv_addr = AW'($urandom);
      clr_req = ($urandom_range(0, 49) == 0);
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr_a : AW'($urandom);
      raddr2 = ($urandom_range(0, 2) == 0) ? waddr_b : AW'($urandom);
      cycle();
    end

    // Let any clear finish, refill, then reset in the middle of a clear.
    idle_inputs();
    for (int k = 0; k < DEPTH + 1; k++) cycle();
    for (int i = 1; i < DEPTH; i++) begin
      we_b = 1; waddr_b = i[AW-1:0]; wdata_b = 8'h80 | 8'(i);
      rsv_en = 1; rsv_addr = i[AW-1:0];
      cycle();
      idle_inputs(); rsv_en = 1; rsv_addr = i[AW-1:0];
      cycle();
    end
    idle_inputs(); clr_req = 1;
    cycle();
    idle_inputs();
    for (int k = 0; k < 3; k++) cycle();
    check_eq("pre_rst_clr_busy", clr_busy, 1);
    rst = 1'b1;
    model_reset();
    #1 check_eq("rst_mid_clear", clr_busy, 0);
    sweep_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_idle", clr_busy, 0);
    for (int k = 0; k < 20; k++) begin
      we_a = 1'($urandom_range(0, 1)); waddr_a = AW'($urandom); wdata_a = DW'($urandom);
      rsv_en = 1'($urandom_range(0, 1)); rsv_addr = AW'($urandom);
      raddr1 = AW'($urandom); raddr2 = waddr_a;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
